// File: rtl/fb_pkg.sv
// Shared frame-buffer definitions: geometry, arbitration slot encoding and
// the pixel-coordinate to linear-address mapping.
package fb_pkg;

    localparam int unsigned FB_W      = 640;
    localparam int unsigned FB_H      = 480;
    localparam int unsigned FB_PIXELS = 307200;

    typedef enum logic [1:0] {
        SLOT_IDLE = 2'd0,
        SLOT_SCAN = 2'd1,
        SLOT_RD   = 2'd2,
        SLOT_WR   = 2'd3
    } slot_e;

    // y*640 + x built from shifts, kept at the full 19-bit width
    function automatic logic [18:0] fb_xy2addr(input logic [9:0] x, input logic [9:0] y);
        logic [18:0] xx;
        logic [18:0] yy;
        xx = {9'd0, x};
        yy = {9'd0, y};
        return (yy << 9) + (yy << 7) + xx;
    endfunction

endpackage

// File: rtl/fb_wr_fifo.sv
// Posted-write FIFO for processor frame-buffer writes; entries are {addr, data}
// and leave in push order. DEPTH must be a power of two.
module fb_wr_fifo
    import fb_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 19,
    parameter int unsigned DW    = 8
)(
    input  logic          clk,
    input  logic          clr,
    input  logic          push,
    input  logic          pop,
    input  logic [AW-1:0] push_addr,
    input  logic [DW-1:0] push_data,
    output logic [AW-1:0] head_addr,
    output logic [DW-1:0] head_data,
    output logic          full,
    output logic          empty
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } entry_t;

    entry_t        mem_q [DEPTH];
    entry_t        mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    // Next-state for storage, pointers and occupancy
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = '{addr: push_addr, data: push_data};
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // FIFO state registers
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_addr = mem_q[rd_ptr_q].addr;
    assign head_data = mem_q[rd_ptr_q].data;
    assign full      = (count_q == CW'(DEPTH));
    assign empty     = (count_q == '0);

endmodule

// File: rtl/fb_arbiter.sv
// Single-port pixel RAM arbiter: scan-out owns every vgaClk-low cycle of active
// video, the processor (posted writes, blocking reads) gets every other cycle.
module fb_arbiter
    import fb_pkg::*;
#(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned ADDR_W     = 19,
    parameter int unsigned FIFO_DEPTH = 4
)(
    input  logic              clk,
    input  logic              clr,
    input  logic              vgaClk,
    input  logic              bgEn,
    input  logic [9:0]        x,
    input  logic [9:0]        y,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_ack,
    output logic [DATA_W-1:0] rd_data,
    output logic [DATA_W-1:0] pix_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              addr_err
);

    logic              fifo_full, fifo_empty, push, pop;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_data;
    logic              wr_oor, rd_oor, rd_busy, rd_issue, rd_oor_issue, err_set, we;
    slot_e             slot;

    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              rd_p1_q, rd_p1_d;
    logic              rd_ack_q, rd_ack_d;
    logic              rd_oor_ack_q, rd_oor_ack_d;
    logic              rd_tail_q, rd_tail_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              pix_load_q, pix_load_d;
    logic              pix_blank_q, pix_blank_d;
    logic [DATA_W-1:0] pix_data_q, pix_data_d;
    logic              addr_err_q, addr_err_d;

    assign push     = wr_valid & ~fifo_full;
    assign wr_ready = ~fifo_full;
    assign wr_oor   = (32'(head_addr) >= FB_PIXELS);
    assign rd_oor   = (32'(rd_addr) >= FB_PIXELS);
    // An out-of-range ack has no data stage, so a tail cycle keeps the
    // same "new request no earlier than slot+3" spacing as a normal read.
    assign rd_busy  = rd_p1_q | rd_ack_q | rd_tail_q;

    fb_wr_fifo #(
        .DEPTH (FIFO_DEPTH),
        .AW    (ADDR_W),
        .DW    (DATA_W)
    ) u_wr_fifo (
        .clk       (clk),
        .clr       (clr),
        .push      (push),
        .pop       (pop),
        .push_addr (wr_addr),
        .push_data (wr_data),
        .head_addr (head_addr),
        .head_data (head_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Slot owner, in strict priority order
    always_comb begin
        slot = SLOT_IDLE;
        if (bgEn && !vgaClk) begin
            slot = SLOT_SCAN;
        end else if (fifo_full && !fifo_empty) begin
            slot = SLOT_WR;
        end else if (rd_req && !rd_busy) begin
            slot = SLOT_RD;
        end else if (!fifo_empty) begin
            slot = SLOT_WR;
        end else begin
            slot = SLOT_IDLE;
        end
    end

    // RAM command for the owning slot; address and write data hold when unused
    always_comb begin
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        we           = 1'b0;
        pop          = 1'b0;
        rd_issue     = 1'b0;
        rd_oor_issue = 1'b0;
        err_set      = 1'b0;
        case (slot)
            SLOT_SCAN: mem_addr_d = ADDR_W'(fb_xy2addr(x, y));
            SLOT_RD: begin
                if (rd_oor) begin
                    rd_oor_issue = 1'b1;
                    err_set      = 1'b1;
                end else begin
                    mem_addr_d = rd_addr;
                    rd_issue   = 1'b1;
                end
            end
            SLOT_WR: begin
                pop = 1'b1;
                if (wr_oor) begin
                    err_set = 1'b1;
                end else begin
                    mem_addr_d  = head_addr;
                    mem_wdata_d = head_data;
                    we          = 1'b1;
                end
            end
            default: mem_addr_d = mem_addr_q;
        endcase
    end

    // Read-return and scan-return pipelines plus the sticky error flag
    always_comb begin
        rd_p1_d      = rd_issue;
        rd_ack_d     = rd_p1_q | rd_oor_issue;
        rd_oor_ack_d = rd_oor_issue;
        rd_tail_d    = rd_ack_q & rd_oor_ack_q;
        if (rd_p1_q) begin
            rd_data_d = mem_rdata;
        end else if (rd_oor_issue) begin
            rd_data_d = '0;
        end else begin
            rd_data_d = rd_data_q;
        end
        pix_load_d  = ~vgaClk & bgEn;
        pix_blank_d = ~vgaClk & ~bgEn;
        if (pix_load_q) begin
            pix_data_d = mem_rdata;
        end else if (pix_blank_q) begin
            pix_data_d = '0;
        end else begin
            pix_data_d = pix_data_q;
        end
        addr_err_d = addr_err_q | err_set;
    end

    // State registers
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            rd_p1_q      <= 1'b0;
            rd_ack_q     <= 1'b0;
            rd_oor_ack_q <= 1'b0;
            rd_tail_q    <= 1'b0;
            rd_data_q    <= '0;
            pix_load_q   <= 1'b0;
            pix_blank_q  <= 1'b0;
            pix_data_q   <= '0;
            addr_err_q   <= 1'b0;
        end else begin
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            rd_p1_q      <= rd_p1_d;
            rd_ack_q     <= rd_ack_d;
            rd_oor_ack_q <= rd_oor_ack_d;
            rd_tail_q    <= rd_tail_d;
            rd_data_q    <= rd_data_d;
            pix_load_q   <= pix_load_d;
            pix_blank_q  <= pix_blank_d;
            pix_data_q   <= pix_data_d;
            addr_err_q   <= addr_err_d;
        end
    end

    assign mem_addr  = mem_addr_d;
    assign mem_wdata = mem_wdata_d;
    assign mem_we    = we;
    assign rd_ack    = rd_ack_q;
    assign rd_data   = rd_data_q;
    assign pix_data  = pix_data_q;
    assign addr_err  = addr_err_q;

endmodule

// File: tb/tb_fb_arbiter.sv
// Directed bench for fb_arbiter: RAM model preloaded with addr[7:0], expected
// RAM writes and read returns queued by the stimulus and checked by a monitor.
module tb_fb_arbiter;

    logic        clk, clr, vgaClk, bgEn;
    logic [9:0]  x, y;
    logic        wr_valid, wr_ready, rd_req, rd_ack, mem_we, addr_err;
    logic [18:0] wr_addr, rd_addr, mem_addr;
    logic [7:0]  wr_data, rd_data, pix_data, mem_wdata, mem_rdata;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [26:0] exp_wr[$];
    logic [7:0]  exp_rd[$];
    logic [7:0]  ram [0:524287];

    fb_arbiter dut (
        .clk(clk), .clr(clr), .vgaClk(vgaClk), .bgEn(bgEn), .x(x), .y(y),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack), .rd_data(rd_data),
        .pix_data(pix_data), .mem_addr(mem_addr), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .addr_err(addr_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Synchronous single-port RAM: command captured mid-cycle, applied at the edge
    initial begin
        logic [18:0] c_addr;
        logic        c_we;
        logic [7:0]  c_wd;
        for (int i = 0; i < 524288; i++) ram[i] = i[7:0];
        mem_rdata = 8'h00;
        forever begin
            @(negedge clk);
            c_addr = mem_addr;
            c_we   = mem_we;
            c_wd   = mem_wdata;
            @(posedge clk);
            mem_rdata <= ram[c_addr];
            if (c_we) ram[c_addr] = c_wd;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        vgaClk = ~vgaClk;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic wait_vga(input logic v);
        tick();
        if (vgaClk != v) tick();
    endtask

    task automatic push_wr(input logic [18:0] a, input logic [7:0] d);
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && exp_wr.size() != 0; i++) tick();
        chk("drain_pending", 32'(exp_wr.size()), 32'd0);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_pix"}, 32'(pix_data), 32'd0);
        chk({tag, "_rd_data"}, 32'(rd_data), 32'd0);
        chk({tag, "_rd_ack"}, 32'(rd_ack), 32'd0);
        chk({tag, "_mem_we"}, 32'(mem_we), 32'd0);
        chk({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
        chk({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
        chk({tag, "_addr_err"}, 32'(addr_err), 32'd0);
        chk({tag, "_wr_ready"}, 32'(wr_ready), 32'd1);
    endtask

    // Monitor: scan slots, RAM writes and read returns against the queues
    initial begin
        logic [26:0] ew;
        logic [7:0]  er;
        forever begin
            @(negedge clk);
            if (!clr) begin
                if (bgEn && !vgaClk) begin
                    chk("scan_addr", 32'(mem_addr), 32'(y) * 32'd640 + 32'(x));
                    chk("scan_no_we", 32'(mem_we), 32'd0);
                end
                if (mem_we) begin
                    if (exp_wr.size() == 0) begin
                        chk("wr_unexpected", 32'(mem_we), 32'd0);
                    end else begin
                        ew = exp_wr.pop_front();
                        chk("wr_order", 32'({mem_addr, mem_wdata}), 32'(ew));
                    end
                end
                if (rd_ack) begin
                    if (exp_rd.size() == 0) begin
                        chk("rd_unexpected", 32'(rd_ack), 32'd0);
                    end else begin
                        er = exp_rd.pop_front();
                        chk("rd_data", 32'(rd_data), 32'(er));
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        clr = 1'b1; bgEn = 1'b0; vgaClk = 1'b1; x = 10'd0; y = 10'd0;
        wr_valid = 1'b0; wr_addr = 19'd0; wr_data = 8'd0; rd_req = 1'b0; rd_addr = 19'd0;
        repeat (3) tick();
        smp();
        chk_reset("por");
        tick();
        clr = 1'b0;

        // Scan: x=3,y=1 -> 643, pixel 8'h83 two cycles later, then x=4 -> 8'h84
        wait_vga(1'b0);
        bgEn = 1'b1; x = 10'd3; y = 10'd1;
        smp(); chk("scan643_addr", 32'(mem_addr), 32'd643);
        tick(); smp(); chk("pix_not_yet", 32'(pix_data), 32'h00);
        tick(); x = 10'd4;
        smp(); chk("pix_83_first", 32'(pix_data), 32'h83);
        tick(); smp(); chk("pix_83_hold", 32'(pix_data), 32'h83);
        tick(); smp(); chk("pix_84", 32'(pix_data), 32'h84);

        // Six back-to-back writes in active video; FIFO fills to 4 after the sixth
        x = 10'd10; y = 10'd2;
        wait_vga(1'b1);
        for (int i = 0; i < 6; i++) begin
            push_wr(19'(10 + i), 8'(8'hA0 + i));
            smp();
            chk("wr_ready_free", 32'(wr_ready), 32'd1);
            exp_wr.push_back({wr_addr, wr_data});
            tick();
        end
        wr_valid = 1'b0; rd_req = 1'b1; rd_addr = 19'd643;
        exp_rd.push_back(8'h83);
        smp(); chk("wr_ready_full", 32'(wr_ready), 32'd0);
        chk("full_wr_before_rd", 32'(mem_we), 32'd1);
        tick(); smp(); chk("wr_ready_back", 32'(wr_ready), 32'd1);
        tick(); smp(); chk("rd_slot_addr", 32'(mem_addr), 32'd643);
        chk("rd_slot_no_we", 32'(mem_we), 32'd0);
        tick(); smp(); chk("rd_ack_early", 32'(rd_ack), 32'd0);
        tick(); smp(); chk("rd_ack_lat", 32'(rd_ack), 32'd1);
        tick(); rd_req = 1'b0;
        drain();

        // Two pending writes, then a read: the read takes the next CPU slot
        wait_vga(1'b1);
        push_wr(19'd20, 8'h5A); exp_wr.push_back({19'd20, 8'h5A});
        tick();
        push_wr(19'd21, 8'h5B); exp_wr.push_back({19'd21, 8'h5B});
        tick();
        wr_valid = 1'b0; rd_req = 1'b1; rd_addr = 19'd12;
        exp_rd.push_back(8'hA2);
        smp(); chk("rd_first_addr", 32'(mem_addr), 32'd12);
        chk("rd_first_no_we", 32'(mem_we), 32'd0);
        tick(); smp(); chk("rd2_ack_early", 32'(rd_ack), 32'd0);
        tick(); smp(); chk("rd2_ack_lat", 32'(rd_ack), 32'd1);
        chk("wr_after_rd", 32'(mem_we), 32'd1);
        tick(); rd_req = 1'b0;
        drain();

        // Blanking: CPU owns every cycle, pixel forced to zero
        bgEn = 1'b0;
        repeat (3) tick();
        for (int i = 0; i < 4; i++) begin
            if (i < 3) begin
                push_wr(19'(30 + i), 8'(8'hC0 + i));
                exp_wr.push_back({wr_addr, wr_data});
            end else begin
                wr_valid = 1'b0;
            end
            smp();
            chk("blank_pix", 32'(pix_data), 32'd0);
            if (i > 0) chk("blank_we_every_cycle", 32'(mem_we), 32'd1);
            tick();
        end

        // Out-of-range write and read
        push_wr(19'd307200, 8'hEE);
        smp(); chk("err_before", 32'(addr_err), 32'd0);
        tick(); wr_valid = 1'b0;
        smp(); chk("oor_wr_no_we", 32'(mem_we), 32'd0);
        tick(); smp(); chk("err_after_wr", 32'(addr_err), 32'd1);
        tick(); rd_req = 1'b1; rd_addr = 19'd307200;
        exp_rd.push_back(8'h00);
        smp(); chk("oor_rd_no_we", 32'(mem_we), 32'd0);
        chk("oor_rd_ack_early", 32'(rd_ack), 32'd0);
        tick(); smp(); chk("oor_rd_ack", 32'(rd_ack), 32'd1);
        tick(); rd_req = 1'b0;
        smp(); chk("oor_rd_single", 32'(rd_ack), 32'd0);
        repeat (4) tick();
        smp(); chk("err_sticky", 32'(addr_err), 32'd1);

        // Reset with a read in flight and a write pending: both dropped
        bgEn = 1'b1;
        wait_vga(1'b1);
        rd_req = 1'b1; rd_addr = 19'd5;
        push_wr(19'd41, 8'h11);
        smp(); chk("pre_rst_rd_addr", 32'(mem_addr), 32'd5);
        tick();
        clr = 1'b1; rd_req = 1'b0; wr_valid = 1'b0; bgEn = 1'b0;
        tick(); tick();
        smp();
        chk_reset("mid_rst");
        tick(); clr = 1'b0;
        repeat (6) tick();
        push_wr(19'd50, 8'h77); exp_wr.push_back({19'd50, 8'h77});
        tick(); wr_valid = 1'b0;
        drain();
        chk("rd_pending", 32'(exp_rd.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
